// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared constants for the write-back stage.
// Holds the load funct3 encodings and the default datapath widths.
package wb_stage_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned RADDR_W_DEF = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_ext.sv
// wb_stage_load_ext: aligns a raw memory word to the addressed byte/half
// and sign- or zero-extends it according to the load funct3.
// Unknown funct3 values produce zero.
module wb_stage_load_ext
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_byte_off,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte lane and half-word (off[0] ignored for halves)
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_byte_off)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_byte_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Extend the selected lane according to the load type
    always_comb begin
        o_data = '0;
        case (i_funct3)
            F3_LB:  o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            F3_LH:  o_data = {{(DATA_W-16){w_half[15]}}, w_half};
            F3_LW:  o_data = i_rdata;
            F3_LBU: o_data = {{(DATA_W-8){1'b0}}, w_byte};
            F3_LHU: o_data = {{(DATA_W-16){1'b0}}, w_half};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage owning the register file write port.
// Merges ALU results (buffered in a small FIFO with flow-through) and load
// data (extended by wb_stage_load_ext) into one registered write per cycle.
// Loads win arbitration, bounded by a starvation counter that forces the
// ALU FIFO head through after STARVE_MAX load wins while the FIFO is full.
// Optional macro WB_FWD_EN adds combinational write-to-read forwarding ports.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned RADDR_W    = RADDR_W_DEF,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [RADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]  alu_data,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [RADDR_W-1:0] ld_rd,
    input  logic [2:0]         ld_funct3,
    input  logic [1:0]         ld_byte_off,
    input  logic [DATA_W-1:0]  ld_rdata,
    output logic               reg_wen,
    output logic [RADDR_W-1:0] reg_waddr,
    output logic [DATA_W-1:0]  reg_wdata,
    output logic               busy
`ifdef WB_FWD_EN
   ,input  logic [RADDR_W-1:0] reg1_raddr,
    input  logic [RADDR_W-1:0] reg2_raddr,
    input  logic [DATA_W-1:0]  rf1_rdata,
    input  logic [DATA_W-1:0]  rf2_rdata,
    output logic [DATA_W-1:0]  fwd1_rdata,
    output logic [DATA_W-1:0]  fwd2_rdata
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);

    // FIFO storage and bookkeeping
    logic [RADDR_W-1:0] r_fifo_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0]  r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic [SC_W-1:0]    r_starve;

    // Output registers
    logic               r_wen;
    logic [RADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0]  r_wdata;

    logic               w_empty;
    logic               w_full;
    logic               w_force;
    logic               w_ld_hs;
    logic               w_alu_hs;
    logic               w_alu_keep;
    logic               w_flow;
    logic               w_push;
    logic               w_pop;
    logic               w_alu_issue;
    logic               w_issue;
    logic [RADDR_W-1:0] w_iss_rd;
    logic [DATA_W-1:0]  w_iss_data;
    logic [DATA_W-1:0]  w_ld_ext;

    wb_stage_load_ext #(
        .DATA_W (DATA_W)
    ) u_load_ext (
        .i_funct3   (ld_funct3),
        .i_byte_off (ld_byte_off),
        .i_rdata    (ld_rdata),
        .o_data     (w_ld_ext)
    );

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_force = w_full && (r_starve == SC_W'(STARVE_MAX));

    // Readies are held low during reset so nothing is accepted
    assign alu_ready = !arst && !w_full;
    assign ld_ready  = !arst && !w_force;

    assign w_ld_hs     = ld_valid && ld_ready;
    assign w_alu_hs    = alu_valid && alu_ready;
    // x0 results are acknowledged but dropped
    assign w_alu_keep  = w_alu_hs && (alu_rd != '0);
    assign w_flow      = w_alu_keep && w_empty && !w_ld_hs;
    assign w_push      = w_alu_keep && !w_flow;
    assign w_pop       = !w_ld_hs && !w_empty;
    assign w_alu_issue = w_pop || w_flow;

    // Issue mux: load first, then FIFO head, then flow-through ALU entry
    always_comb begin
        w_issue    = 1'b0;
        w_iss_rd   = '0;
        w_iss_data = '0;
        if (w_ld_hs) begin
            w_issue    = 1'b1;
            w_iss_rd   = ld_rd;
            w_iss_data = w_ld_ext;
        end else if (w_pop) begin
            w_issue    = 1'b1;
            w_iss_rd   = r_fifo_rd[r_rptr];
            w_iss_data = r_fifo_data[r_rptr];
        end else if (w_flow) begin
            w_issue    = 1'b1;
            w_iss_rd   = alu_rd;
            w_iss_data = alu_data;
        end
    end

    // FIFO payload storage (contents are don't-care while empty)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= alu_rd;
            r_fifo_data[r_wptr] <= alu_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Starvation counter: counts load wins while the FIFO stays full
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_starve <= '0;
        end else if (!w_full || w_alu_issue) begin
            r_starve <= '0;
        end else if (w_ld_hs && (r_starve != SC_W'(STARVE_MAX))) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Registered write port; x0 destinations never raise the enable
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= w_issue && (w_iss_rd != '0);
            if (w_issue) begin
                r_waddr <= w_iss_rd;
                r_wdata <= w_iss_data;
            end
        end
    end

    assign reg_wen   = r_wen;
    assign reg_waddr = r_waddr;
    assign reg_wdata = r_wdata;
    assign busy      = !w_empty || r_wen;

`ifdef WB_FWD_EN
    // Bypass the pending write onto matching register file reads
    always_comb begin
        fwd1_rdata = rf1_rdata;
        fwd2_rdata = rf2_rdata;
        if (r_wen && (r_waddr == reg1_raddr) && (reg1_raddr != '0)) begin
            fwd1_rdata = r_wdata;
        end
        if (r_wen && (r_waddr == reg2_raddr) && (reg2_raddr != '0)) begin
            fwd2_rdata = r_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage. Stimulus pushes expected
// register writes (tagged with the cycle they must appear in) into a queue;
// a negedge monitor pops and compares, and flags any unexpected write.
module tb_wb_stage;

    logic        clk;
    logic        arst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_byte_off;
    logic [31:0] ld_rdata;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        busy;
`ifdef WB_FWD_EN
    logic [4:0]  reg1_raddr;
    logic [4:0]  reg2_raddr;
    logic [31:0] rf1_rdata;
    logic [31:0] rf2_rdata;
    logic [31:0] fwd1_rdata;
    logic [31:0] fwd2_rdata;
`endif

    wb_stage #(
        .DATA_W     (32),
        .RADDR_W    (5),
        .FIFO_DEPTH (2),
        .STARVE_MAX (4)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_funct3   (ld_funct3),
        .ld_byte_off (ld_byte_off),
        .ld_rdata    (ld_rdata),
        .reg_wen     (reg_wen),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata),
        .busy        (busy)
`ifdef WB_FWD_EN
       ,.reg1_raddr  (reg1_raddr),
        .reg2_raddr  (reg2_raddr),
        .rf1_rdata   (rf1_rdata),
        .rf2_rdata   (rf2_rdata),
        .fwd1_rdata  (fwd1_rdata),
        .fwd2_rdata  (fwd2_rdata)
`endif
    );

    typedef struct {
        int unsigned cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle either the expected write appears or no write does
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_write actual none required rd=%0d data=%h at cycle %0d",
                     e.addr, e.data, e.cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            checks++;
            if (!(reg_wen === 1'b1 && reg_waddr === e.addr && reg_wdata === e.data)) begin
                errors++;
                $display("FAIL write actual wen=%b rd=%0d data=%h required wen=1 rd=%0d data=%h (cycle %0d)",
                         reg_wen, reg_waddr, reg_wdata, e.addr, e.data, cyc);
            end
        end else begin
            checks++;
            if (reg_wen !== 1'b0) begin
                errors++;
                $display("FAIL unexpected_write actual wen=%b rd=%0d data=%h required wen=0 (cycle %0d)",
                         reg_wen, reg_waddr, reg_wdata, cyc);
            end
        end
    end

    task automatic clear_inputs();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        ld_valid    = 1'b0;
        ld_rd       = '0;
        ld_funct3   = '0;
        ld_byte_off = '0;
        ld_rdata    = '0;
    endtask

    // One cycle of stimulus plus ready checks before the edge
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                        input logic [1:0] off, input logic [31:0] lrdata,
                        input logic e_ar, input logic e_lr);
        @(posedge clk);
        #1;
        alu_valid   = av;
        alu_rd      = ard;
        alu_data    = ad;
        ld_valid    = lv;
        ld_rd       = lrd;
        ld_funct3   = f3;
        ld_byte_off = off;
        ld_rdata    = lrdata;
        #1;
        chk("alu_ready", alu_ready, e_ar);
        chk("ld_ready", ld_ready, e_lr);
    endtask

    // Expect the write issued in the current cycle to appear next cycle
    task automatic expect_w(input logic [4:0] addr, input logic [31:0] data);
        q.push_back('{cyc + 1, addr, data});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            clear_inputs();
        end
    endtask

    localparam logic [31:0] RD = 32'h80FF7F01;

    initial begin
        clear_inputs();
`ifdef WB_FWD_EN
        reg1_raddr = '0;
        reg2_raddr = '0;
        rf1_rdata  = '0;
        rf2_rdata  = '0;
`endif
        arst = 1'b1;
        #3;
        chk("rst_wen", reg_wen, 0);
        chk("rst_waddr", reg_waddr, 0);
        chk("rst_wdata", reg_wdata, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        idle(2);

        // ALU alone, flow-through
        step(1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 1, 1);
        expect_w(5'd5, 32'h1234);
        step(1, 5'd0, 32'hDEAD, 0, 0, 0, 0, 0, 1, 1);
        @(posedge clk);
        #1;
        clear_inputs();
        #1;
        chk("busy_after_x0", busy, 0);
        idle(1);

        // Load extension
        step(0, 0, 0, 1, 5'd1, 3'b000, 2'd1, RD, 1, 1); expect_w(5'd1, 32'h0000007F);
        step(0, 0, 0, 1, 5'd2, 3'b000, 2'd2, RD, 1, 1); expect_w(5'd2, 32'hFFFFFFFF);
        step(0, 0, 0, 1, 5'd3, 3'b001, 2'd2, RD, 1, 1); expect_w(5'd3, 32'hFFFF80FF);
        step(0, 0, 0, 1, 5'd4, 3'b101, 2'd2, RD, 1, 1); expect_w(5'd4, 32'h000080FF);
        step(0, 0, 0, 1, 5'd5, 3'b010, 2'd0, RD, 1, 1); expect_w(5'd5, 32'h80FF7F01);
        step(0, 0, 0, 1, 5'd6, 3'b011, 2'd0, RD, 1, 1); expect_w(5'd6, 32'h00000000);
        step(0, 0, 0, 1, 5'd8, 3'b001, 2'd3, RD, 1, 1); expect_w(5'd8, 32'hFFFF80FF);
        step(0, 0, 0, 1, 5'd9, 3'b100, 2'd3, RD, 1, 1); expect_w(5'd9, 32'h00000080);
        step(0, 0, 0, 1, 5'd10, 3'b000, 2'd0, RD, 1, 1); expect_w(5'd10, 32'h00000001);
        step(0, 0, 0, 1, 5'd0, 3'b010, 2'd0, RD, 1, 1);
        idle(2);

        // Priority: load first, ALU result next cycle
        step(1, 5'd6, 32'h66, 1, 5'd4, 3'b010, 2'd0, 32'h44, 1, 1);
        expect_w(5'd4, 32'h44);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        expect_w(5'd6, 32'h66);
        chk("busy_fifo", busy, 1);
        idle(2);

        // Starvation: fill FIFO, four load wins, then forced ALU head
        step(1, 5'd11, 32'hA1, 1, 5'd12, 3'b010, 2'd0, 32'hC1, 1, 1); expect_w(5'd12, 32'hC1);
        step(1, 5'd13, 32'hB1, 1, 5'd14, 3'b010, 2'd0, 32'hC2, 1, 1); expect_w(5'd14, 32'hC2);
        for (int i = 0; i < 4; i++) begin
            step(1, 5'd15, 32'hCC, 1, 5'(16 + i), 3'b010, 2'd0, 32'hD0 + 32'(i), 0, 1);
            expect_w(5'(16 + i), 32'hD0 + 32'(i));
        end
        step(1, 5'd15, 32'hCC, 1, 5'd20, 3'b010, 2'd0, 32'hEE, 0, 0);
        expect_w(5'd11, 32'hA1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        expect_w(5'd13, 32'hB1);
        idle(3);

        // Mid-stream reset with two entries queued
        step(1, 5'd9, 32'h99, 1, 5'd2, 3'b010, 2'd0, 32'h22, 1, 1);
        expect_w(5'd2, 32'h22);
        step(1, 5'd10, 32'hAA, 1, 5'd3, 3'b010, 2'd0, 32'h33, 1, 1);
        @(posedge clk);
        #1;
        clear_inputs();
        chk("busy_before_rst", busy, 1);
        arst = 1'b1;
        #1;
        chk("mid_rst_wen", reg_wen, 0);
        chk("mid_rst_waddr", reg_waddr, 0);
        chk("mid_rst_wdata", reg_wdata, 0);
        chk("mid_rst_alu_ready", alu_ready, 0);
        chk("mid_rst_ld_ready", ld_ready, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        arst = 1'b0;
        idle(4);
        chk("busy_after_rst", busy, 0);

`ifdef WB_FWD_EN
        // Forwarding of the pending write
        step(1, 5'd7, 32'hA5, 0, 0, 0, 0, 0, 1, 1);
        expect_w(5'd7, 32'hA5);
        @(posedge clk);
        #1;
        clear_inputs();
        reg1_raddr = 5'd7;
        rf1_rdata  = 32'h11;
        reg2_raddr = 5'd0;
        rf2_rdata  = 32'h22;
        #1;
        chk("fwd1_hit", fwd1_rdata, 32'hA5);
        chk("fwd2_x0", fwd2_rdata, 32'h22);
        @(posedge clk);
        #2;
        chk("fwd1_idle", fwd1_rdata, 32'h11);
        idle(1);
`endif

        idle(3);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
